// File: rtl/sat_pkg.sv
// ============================================================================
// Package     : sat_pkg
// Description : Shared widths, literal layout and checker state encoding for
//               the clause checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sat_pkg;

  // Variable id width the literal_t view is laid out for.
  localparam int unsigned DEF_VAR_ID_BITS = 8;

  // Literal width: a negation flag above the variable id.
  function automatic int unsigned lit_w(input int unsigned var_id_bits);
    return var_id_bits + 1;
  endfunction

  // Clause width: literals packed side by side, literal 0 in the LSBs.
  function automatic int unsigned clause_w(input int unsigned var_id_bits,
                                           input int unsigned num_vars);
    return lit_w(var_id_bits) * num_vars;
  endfunction

  // One literal as stored in the clause memory.
  typedef struct packed {
    logic                       neg;
    logic [DEF_VAR_ID_BITS-1:0] var_id;
  } literal_t;

  // Checker sweep control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } chk_state_t;

endpackage

`default_nettype wire

// File: rtl/clause_eval_lane.sv
// ============================================================================
// Module      : clause_eval_lane
// Description : Combinational evaluation of one clause against the latched
//               assignment. Variable id 0 marks a padding literal that is
//               never true.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clause_eval_lane
  import sat_pkg::*;
#(
  parameter int VAR_ID_BITS         = 8,
  parameter int NUM_VARS_PER_CLAUSE = 3,
  localparam int LW = lit_w(VAR_ID_BITS),
  localparam int CW = clause_w(VAR_ID_BITS, NUM_VARS_PER_CLAUSE)
) (
  input  logic [CW-1:0]             i_clause,
  input  logic [2**VAR_ID_BITS-1:0] i_assignment,
  output logic                      o_unsat
);

  logic w_any_true;

  // A clause holds as soon as one of its non-padding literals is true.
  always_comb begin
    w_any_true = 1'b0;
    for (int j = 0; j < NUM_VARS_PER_CLAUSE; j++) begin
      if ((i_clause[j*LW +: VAR_ID_BITS] != '0) &&
          (i_assignment[i_clause[j*LW +: VAR_ID_BITS]] ^ i_clause[j*LW + VAR_ID_BITS])) begin
        w_any_true = 1'b1;
      end
    end
  end

  assign o_unsat = ~w_any_true;

endmodule

`default_nettype wire

// File: rtl/clause_checker.sv
// ============================================================================
// Module      : clause_checker
// Description : Sweeps the clause memory one row per cycle, evaluates every
//               clause against an assignment latched at start, and reports
//               satisfaction, unsatisfied count and lowest unsatisfied index.
//               Optional macro CLAUSE_CHECKER_MASK_EN adds the full
//               per-clause unsat_mask output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clause_checker
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW       = clause_w(VAR_ID_BITS, NUM_VARS_PER_CLAUSE),
  localparam int SLICE_W  = CW * NUM_CLAUSES_PER_CYCLE,
  localparam int CNT_W    = $clog2(NUM_CLAUSES + 1),
  localparam int IDX_W    = $clog2(NUM_CLAUSES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2**VAR_ID_BITS-1:0] assignment,
  input  logic [SLICE_W-1:0]        mem_slice,
  input  logic [ROW_W-1:0]          mem_row,
  output logic                      busy,
  output logic                      done,
  output logic                      sat,
  output logic [CNT_W-1:0]          unsat_count,
  output logic                      first_unsat_valid,
  output logic [IDX_W-1:0]          first_unsat_idx,
  output logic                      resync
`ifdef CLAUSE_CHECKER_MASK_EN
  ,
  output logic [NUM_CLAUSES-1:0]    unsat_mask
`endif
);

  localparam int K_W = (NUM_CLAUSES_PER_CYCLE > 1) ? $clog2(NUM_CLAUSES_PER_CYCLE) : 1;

  chk_state_t                  r_state;
  chk_state_t                  w_state_nxt;
  logic                        w_accept;
  logic                        w_eval;
  logic                        w_mismatch;

  logic [2**VAR_ID_BITS-1:0]   r_assign_q;
  logic [ROW_W-1:0]            r_exp_row;

  logic [NUM_CLAUSES_PER_CYCLE-1:0] w_lane_unsat;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] r_s1_mask;
  logic [ROW_W-1:0]                 r_s1_row;
  logic                             r_s1_valid;

  logic [CNT_W-1:0]            w_pop;
  logic [K_W-1:0]              w_low_k;
  logic [CNT_W-1:0]            r_acc_cnt;
  logic [CNT_W-1:0]            w_acc_cnt_nxt;
  logic                        r_acc_found;
  logic                        w_acc_found_nxt;
  logic [IDX_W-1:0]            r_acc_idx;
  logic [IDX_W-1:0]            w_acc_idx_nxt;

  logic                        r_sat;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_valid;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_resync;

  // One evaluation lane per clause position in the slice.
  for (genvar k = 0; k < NUM_CLAUSES_PER_CYCLE; k++) begin : g_lane
    clause_eval_lane #(
      .VAR_ID_BITS         (VAR_ID_BITS),
      .NUM_VARS_PER_CLAUSE (NUM_VARS_PER_CLAUSE)
    ) u_lane (
      .i_clause     (mem_slice[k*CW +: CW]),
      .i_assignment (r_assign_q),
      .o_unsat      (w_lane_unsat[k])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_eval      = 1'b0;
    w_mismatch  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (mem_row == '0) begin
          w_eval      = 1'b1;
          w_state_nxt = (NUM_ROWS == 1) ? DRAIN : SWEEP;
        end
      end
      SWEEP: begin
        if (mem_row == r_exp_row) begin
          w_eval = 1'b1;
          if (r_exp_row == ROW_W'(NUM_ROWS - 1)) begin
            w_state_nxt = DRAIN;
          end
        end else begin
          w_mismatch  = 1'b1;
          w_state_nxt = SYNC;
        end
      end
      DRAIN:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the assignment on start and track the row we expect next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_assign_q <= '0;
      r_exp_row  <= '0;
    end else begin
      if (w_accept) begin
        r_assign_q <= assignment;
      end
      if (r_state == SYNC && w_eval) begin
        r_exp_row <= ROW_W'(1);
      end else if (r_state == SWEEP && w_eval) begin
        r_exp_row <= r_exp_row + ROW_W'(1);
      end
    end
  end

  // Stage 1: capture the slice's unsat mask; a resync drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst || w_mismatch) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= '0;
      r_s1_row   <= '0;
    end else begin
      r_s1_valid <= w_eval;
      r_s1_mask  <= w_lane_unsat;
      r_s1_row   <= mem_row;
    end
  end

  // Stage 2 combinational: mask popcount and lowest set position.
  always_comb begin
    w_pop   = '0;
    w_low_k = '0;
    for (int k = NUM_CLAUSES_PER_CYCLE - 1; k >= 0; k--) begin
      w_pop = w_pop + CNT_W'(r_s1_mask[k]);
      if (r_s1_mask[k]) begin
        w_low_k = K_W'(k);
      end
    end
  end

  // Stage 2 next values: rows arrive in ascending order, so the first
  // non-empty mask holds the globally lowest unsatisfied clause.
  always_comb begin
    w_acc_cnt_nxt   = r_acc_cnt;
    w_acc_found_nxt = r_acc_found;
    w_acc_idx_nxt   = r_acc_idx;
    if (r_s1_valid) begin
      w_acc_cnt_nxt = r_acc_cnt + w_pop;
      if (!r_acc_found && (r_s1_mask != '0)) begin
        w_acc_found_nxt = 1'b1;
        w_acc_idx_nxt   = IDX_W'(r_s1_row) * IDX_W'(NUM_CLAUSES_PER_CYCLE) + IDX_W'(w_low_k);
      end
    end
  end

  // Stage 2 accumulators, restarted on a new sweep or a resync.
  always_ff @(posedge clk) begin
    if (rst || w_accept || w_mismatch) begin
      r_acc_cnt   <= '0;
      r_acc_found <= 1'b0;
      r_acc_idx   <= '0;
    end else begin
      r_acc_cnt   <= w_acc_cnt_nxt;
      r_acc_found <= w_acc_found_nxt;
      r_acc_idx   <= w_acc_idx_nxt;
    end
  end

  // Result registers load as the last row accumulates so they show in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat    <= 1'b0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_resync <= 1'b0;
    end else begin
      r_resync <= w_mismatch;
      if (r_state == DRAIN) begin
        r_sat   <= (w_acc_cnt_nxt == '0);
        r_cnt   <= w_acc_cnt_nxt;
        r_valid <= (w_acc_cnt_nxt != '0);
        r_idx   <= w_acc_idx_nxt;
      end
    end
  end

`ifdef CLAUSE_CHECKER_MASK_EN
  logic [NUM_CLAUSES-1:0] r_unsat_mask;

  // Per-clause unsat flags written one row at a time from stage 1.
  always_ff @(posedge clk) begin
    if (rst || w_accept || w_mismatch) begin
      r_unsat_mask <= '0;
    end else if (r_s1_valid) begin
      r_unsat_mask[r_s1_row*NUM_CLAUSES_PER_CYCLE +: NUM_CLAUSES_PER_CYCLE] <= r_s1_mask;
    end
  end

  assign unsat_mask = r_unsat_mask;
`endif

  assign busy              = (r_state != IDLE);
  assign done              = (r_state == DONE);
  assign sat               = r_sat;
  assign unsat_count       = r_cnt;
  assign first_unsat_valid = r_valid;
  assign first_unsat_idx   = r_idx;
  assign resync            = r_resync;

endmodule

`default_nettype wire

// File: tb/tb_clause_checker.sv
// ============================================================================
// Module      : tb_clause_checker
// Description : Self-checking bench for clause_checker. A streaming memory
//               model cycles mem_row; expected results come from evaluating
//               the clause table directly against the latched assignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clause_checker;

  localparam int NC   = 64;
  localparam int NCPC = 16;
  localparam int NV   = 3;
  localparam int LW   = 9;
  localparam int CW   = LW * NV;
  localparam int SW   = CW * NCPC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [255:0]  assignment;
  logic [SW-1:0] mem_slice;
  logic [1:0]    mem_row;
  logic          busy;
  logic          done;
  logic          sat;
  logic [6:0]    unsat_count;
  logic          first_unsat_valid;
  logic [5:0]    first_unsat_idx;
  logic          resync;
`ifdef CLAUSE_CHECKER_MASK_EN
  logic [63:0]   unsat_mask;
`endif

  clause_checker dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .assignment        (assignment),
    .mem_slice         (mem_slice),
    .mem_row           (mem_row),
    .busy              (busy),
    .done              (done),
    .sat               (sat),
    .unsat_count       (unsat_count),
    .first_unsat_valid (first_unsat_valid),
    .first_unsat_idx   (first_unsat_idx),
    .resync            (resync)
`ifdef CLAUSE_CHECKER_MASK_EN
    ,
    .unsat_mask        (unsat_mask)
`endif
  );

  always #5 clk = ~clk;

  // Clause table: lits[c][j] = {neg, var_id}
  logic [8:0] lits [NC][NV];

  // Memory model: the slice for the current row pointer.
  always_comb begin
    mem_slice = '0;
    for (int k = 0; k < NCPC; k++) begin
      for (int j = 0; j < NV; j++) begin
        mem_slice[k*CW + j*LW +: LW] = lits[int'(mem_row)*NCPC + k][j];
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;
  int step_no = 0;
  int last_row3_step = -100;
  int forced_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic drive_row();
    if (forced_q.size() > 0) mem_row = 2'(forced_q.pop_front());
    else                     mem_row = mem_row + 2'd1;
    if (mem_row == 2'd3) last_row3_step = step_no;
  endtask

  task automatic tick();
    step();
    drive_row();
  endtask

  task automatic rand_asg();
    for (int w = 0; w < 8; w++) assignment[w*32 +: 32] = $urandom();
  endtask

  // Reference: a clause is unsatisfied when no literal with a nonzero
  // variable evaluates true under the assignment.
  task automatic ref_eval(input logic [255:0] a, output int cnt, output int first,
                          output logic [63:0] m);
    cnt = 0; first = -1; m = '0;
    for (int c = 0; c < NC; c++) begin
      bit any = 0;
      for (int j = 0; j < NV; j++) begin
        int v = int'(lits[c][j][7:0]);
        if (v != 0 && (a[v] ^ lits[c][j][8])) any = 1;
      end
      if (!any) begin
        cnt++;
        m[c] = 1'b1;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic fill_all(input logic [8:0] lit);
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < NV; j++) lits[c][j] = lit;
  endtask

  task automatic fill_random();
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < NV; j++)
        lits[c][j] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
  endtask

  task automatic run_sweep(input string nm, input int start_row, input bit glitch);
    int ecnt, efirst, done_step, dones, resyncs, busy_after;
    logic [63:0] emask;
    logic [255:0] latched;
    for (int i = 0; i < 8 && mem_row != 2'(start_row); i++) tick();
    start   = 1'b1;
    latched = assignment;
    ref_eval(latched, ecnt, efirst, emask);
    if (glitch) forced_q = '{0, 1, 3};
    tick();
    start = 1'b0;
    rand_asg();
    dones = 0; resyncs = 0; busy_after = 0; done_step = -1;
    for (int i = 0; i < 80 && done_step < 0; i++) begin
      step();
      if (resync) resyncs++;
      if (done) begin
        done_step = step_no;
        dones++;
        chk({nm, "/sat"},   64'(sat), 64'(ecnt == 0));
        chk({nm, "/count"}, 64'(unsat_count), 64'(ecnt));
        chk({nm, "/valid"}, 64'(first_unsat_valid), 64'(ecnt != 0));
        chk({nm, "/idx"},   64'(first_unsat_idx), 64'((efirst < 0) ? 0 : efirst));
        chk({nm, "/busy_at_done"}, 64'(busy), 64'd1);
        chk({nm, "/latency"}, 64'(done_step - last_row3_step), 64'd2);
`ifdef CLAUSE_CHECKER_MASK_EN
        chk({nm, "/mask"}, unsat_mask, emask);
`endif
      end
      start = (i == 3);
      drive_row();
    end
    start = 1'b0;
    if (done_step < 0) chk({nm, "/timeout"}, 64'd0, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy) busy_after++;
      if (done) dones++;
      if (resync) resyncs++;
      drive_row();
    end
    chk({nm, "/no_restart"}, 64'(busy_after), 64'd0);
    chk({nm, "/done_count"}, 64'(dones), 64'd1);
    chk({nm, "/resync_count"}, 64'(resyncs), 64'(glitch ? 1 : 0));
    chk({nm, "/held_count"}, 64'(unsat_count), 64'(ecnt));
  endtask

  task automatic case3_table();
    fill_all(9'h005);
    for (int j = 0; j < NV; j++) lits[37][j] = 9'h105;
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; mem_row = 2'd0; assignment = '0;
    fill_all(9'h000);
    repeat (3) tick();
    rst = 1'b0;
    chk("reset/busy",  64'(busy), 64'd0);
    chk("reset/done",  64'(done), 64'd0);
    chk("reset/sat",   64'(sat), 64'd0);
    chk("reset/count", 64'(unsat_count), 64'd0);
    chk("reset/valid", 64'(first_unsat_valid), 64'd0);
    chk("reset/idx",   64'(first_unsat_idx), 64'd0);
    chk("reset/resync", 64'(resync), 64'd0);

    // All padding: every clause unsatisfied.
    rand_asg();
    run_sweep("pad", 0, 1'b0);

    // Every clause {0,var5} with var5 = 1: formula satisfied.
    fill_all(9'h005);
    rand_asg(); assignment[5] = 1'b1;
    run_sweep("allsat", 1, 1'b0);

    // Only clause 37 fails; start while mem_row = 2.
    case3_table();
    rand_asg(); assignment[5] = 1'b1;
    run_sweep("c37", 2, 1'b0);

    // Row sequence 0,1,3 forces a resync and a full re-sweep.
    rand_asg(); assignment[5] = 1'b1;
    run_sweep("resync", 3, 1'b1);

    // Random tables and assignments.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      rand_asg();
      run_sweep($sformatf("rand%0d", t), $urandom_range(0, 3), t[0]);
    end

    // Reset during SWEEP: idle next cycle, outputs cleared, no done.
    case3_table();
    rand_asg(); assignment[5] = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst/busy",  64'(busy), 64'd0);
    chk("midrst/done",  64'(done), 64'd0);
    chk("midrst/sat",   64'(sat), 64'd0);
    chk("midrst/count", 64'(unsat_count), 64'd0);
    chk("midrst/valid", 64'(first_unsat_valid), 64'd0);
    chk("midrst/idx",   64'(first_unsat_idx), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("midrst/no_done", 64'(dones), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clause_checker.md
Name: clause_checker

Overview:
Consumes the per-cycle clause slices streamed by the static clause memory and evaluates every clause against a latched variable assignment.
- One full sweep covers NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE rows.
- Reports whether the formula is satisfied, the count of unsatisfied clauses, and the lowest-index unsatisfied clause.
- Sits directly downstream of the clause memory and feeds the variable-flip / search control stage.

Parameters:
- NUM_CLAUSES, 64, total clauses; must be a multiple of NUM_CLAUSES_PER_CYCLE.
- VAR_ID_BITS, 8, variable id width; literal width LW = VAR_ID_BITS+1.
- NUM_CLAUSES_PER_CYCLE, 16, clauses per memory slice.
- NUM_VARS_PER_CLAUSE, 3, literals per clause.
- NUM_ROWS, NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE (derived, 4), slices per sweep.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- assignment  in  2**VAR_ID_BITS  variable values; bit v = value of var v; latched on accepted start.
- mem_slice  in  LW*NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE  clause slice from memory.
- mem_row  in  $clog2(NUM_ROWS)  row index of current mem_slice (memory row pointer).
- busy  out  1  high from accepted start until done pulse inclusive.
- done  out  1  one-cycle pulse; result outputs valid and held from then until next accepted start.
- sat  out  1  all clauses satisfied.
- unsat_count  out  $clog2(NUM_CLAUSES+1)  number of unsatisfied clauses.
- first_unsat_valid  out  1  unsat_count != 0.
- first_unsat_idx  out  $clog2(NUM_CLAUSES)  global index of the lowest unsatisfied clause; 0 if none.
- resync  out  1  one-cycle pulse on a row-sequence error.

Behaviour:
- Encoding: clause k of slice = mem_slice[k*LW*NUM_VARS_PER_CLAUSE +: LW*NUM_VARS_PER_CLAUSE]; literal j within it = [j*LW +: LW] = {neg, var_id}.
- Literal true iff var_id != 0 and (assignment_q[var_id] ^ neg). var_id 0 is a padding literal, always false.
- Clause satisfied iff any literal is true. Global index = row*NUM_CLAUSES_PER_CYCLE + k.
- Reset values: all outputs 0; state IDLE; accumulators cleared.
- FSM states:
  - IDLE: start=1 latches assignment into assignment_q, clears accumulators, asserts busy, goes to SYNC.
  - SYNC: waits for mem_row==0. On that cycle, evaluates the slice and goes to SWEEP with expected row = 1.
  - SWEEP: each cycle requires mem_row == expected row and evaluates the slice. After row NUM_ROWS-1 is evaluated, goes to DRAIN.
  - DRAIN: one cycle for the accumulate stage, then DONE.
  - DONE: done=1 for one cycle, outputs updated, returns to IDLE.
- Pipeline:
  - Stage 1 registers the per-clause unsat mask (NUM_CLAUSES_PER_CYCLE bits) plus row.
  - Stage 2 adds the mask popcount to unsat_count and, if none is recorded yet, priority-encodes the lowest set bit into first_unsat_idx.
- Latency: done asserts 2 cycles after the cycle row NUM_ROWS-1 is sampled.
- Row mismatch in SWEEP: pulse resync, clear accumulators, discard in-flight stage-1 data, return to SYNC.
- start while busy: ignored. assignment changes after latch: ignored.
- rst mid-sweep: returns to IDLE next cycle; no done pulse.
- sat = (unsat_count == 0) at DONE.
- unsat_count saturates only by construction; maximum value is NUM_CLAUSES, so no overflow.
- NUM_ROWS == 1: SYNC directly to DRAIN.

Optional Feature:
- Macro: CLAUSE_CHECKER_MASK_EN.
- Defined: adds output unsat_mask [NUM_CLAUSES-1:0]. Bit i = clause i unsatisfied; written row-wise in stage 2; valid with done; cleared on accepted start and on resync.
- Undefined: port and storage absent; all other behaviour identical.

Decomposition:
- Package sat_pkg holds:
  - LW and CLAUSE_W width functions.
  - literal_t struct {neg, var_id}.
  - Checker state enum {IDLE, SYNC, SWEEP, DRAIN, DONE}.
- Sub-module clause_eval_lane: purely combinational, one clause plus assignment_q in, unsat out. Instantiated NUM_CLAUSES_PER_CYCLE times via generate.

Test Plan:
1. All-padding memory (all zeros), any assignment, start -> done with sat=0, unsat_count=64, first_unsat_idx=0.
2. Every clause = {0,var5} and assignment[5]=1 -> sat=1, unsat_count=0, first_unsat_valid=0; done exactly 2 cycles after row 3 sampled.
3. Only clause 37 (row 2, k=5) = {1,var5}, all others satisfied, assignment[5]=1 -> unsat_count=1, first_unsat_idx=37.
4. start asserted while mem_row=2 -> sampling begins at next mem_row=0; results match case 3. Also pulse start during busy -> no second sweep.
5. Bench drives mem_row sequence 0,1,3 -> resync pulse, re-SYNC, then correct sweep 0..3 -> done with correct totals.
6. Assert rst during SWEEP -> next cycle busy=0, all outputs 0, no done. With CLAUSE_CHECKER_MASK_EN defined, case 3 gives unsat_mask = 64'h0000_0020_0000_0000.
